// File: rtl/pending_req_encoder.sv
// Pending-request encoder: rising edges on req_in become sticky pending bits,
// one of which is granted (fixed or rotating priority) and held until accepted.
module pending_req_encoder #(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_in,
  input  logic       out_ready,
  input  logic       clr_ovf,
  output logic       out_valid,
  output logic [2:0] out_code,
  output logic [7:0] out_onehot,
  output logic [7:0] pend,
  output logic       overflow
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t     state;
  logic [7:0] req_q;
  logic [7:0] rise;
  logic [7:0] clr_v;
  logic       accept;
  logic       ovf_set;
  logic [2:0] last_grant;
  logic [2:0] base;
  logic [2:0] idx;
  logic [2:0] sel;
  logic       found;

  assign rise    = req_in & ~req_q;
  assign accept  = (state == HOLD) && out_ready;
  assign clr_v   = accept ? (8'b1 << out_code) : '0;
  // A new edge on a bit being cleared this cycle re-arms it rather than overflowing.
  assign ovf_set = |(rise & pend & ~clr_v);

  always_comb begin
    base  = ROUND_ROBIN ? (last_grant + 3'd1) : 3'd0;
    idx   = '0;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = base + i[2:0];
      if (!found && pend[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q    <= '0;
      pend     <= '0;
      overflow <= 1'b0;
    end else begin
      req_q <= req_in;
      pend  <= (pend & ~clr_v) | rise;
      if (ovf_set)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_code   <= '0;
      out_onehot <= '0;
      last_grant <= 3'd7;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            out_code   <= sel;
            out_onehot <= 8'b1 << sel;
            out_valid  <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            out_onehot <= '0;
            last_grant <= out_code;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pending_req_encoder.sv
// Scoreboard bench: stimulus queues expected grant codes, monitors pop them on accept.
module tb_pending_req_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [7:0] req = '0;
  logic       rdy = 1'b0;
  logic       clr = 1'b0;
  logic       valid;
  logic [2:0] code;
  logic [7:0] onehot;
  logic [7:0] pend;
  logic       ovf;

  logic [7:0] req2 = '0;
  logic       rdy2 = 1'b0;
  logic       valid2;
  logic [2:0] code2;
  logic [7:0] onehot2;
  logic [7:0] pend2;
  logic       ovf2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] q_fix[$];
  logic [2:0] q_rr[$];

  always #5 clk = ~clk;

  pending_req_encoder #(.ROUND_ROBIN(1'b0)) u_fix (
    .clk(clk), .rst(rst), .req_in(req), .out_ready(rdy), .clr_ovf(clr),
    .out_valid(valid), .out_code(code), .out_onehot(onehot), .pend(pend), .overflow(ovf)
  );

  pending_req_encoder #(.ROUND_ROBIN(1'b1)) u_rr (
    .clk(clk), .rst(rst), .req_in(req2), .out_ready(rdy2), .clr_ovf(1'b0),
    .out_valid(valid2), .out_code(code2), .out_onehot(onehot2), .pend(pend2), .overflow(ovf2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [2:0] e;
    if (!rst && valid && rdy) begin
      if (q_fix.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL fix_unexpected_grant: got code %0d expected no grant", code);
      end else begin
        e = q_fix.pop_front();
        chk("fix_code", 32'(code), 32'(e));
        chk("fix_onehot", 32'(onehot), 32'(8'b1 << e));
      end
    end
  end

  always @(negedge clk) begin
    logic [2:0] e;
    if (!rst && valid2 && rdy2) begin
      if (q_rr.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rr_unexpected_grant: got code %0d expected no grant", code2);
      end else begin
        e = q_rr.pop_front();
        chk("rr_code", 32'(code2), 32'(e));
        chk("rr_onehot", 32'(onehot2), 32'(8'b1 << e));
      end
    end
  end

  initial begin
    // Reset state, before any clock edge
    #2;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_onehot", 32'(onehot), 32'd0);
    chk("rst_pend", 32'(pend), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_rr_valid", 32'(valid2), 32'd0);
    #10 rst = 1'b0;
    tick();

    // Single request, two-cycle latency, accept
    req = 8'h04;
    tick();
    chk("single_pend", 32'(pend), 32'h04);
    chk("single_notyet", 32'(valid), 32'd0);
    tick();
    chk("single_valid", 32'(valid), 32'd1);
    chk("single_code", 32'(code), 32'd2);
    chk("single_onehot", 32'(onehot), 32'h04);
    q_fix.push_back(3'd2);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("single_pend_clr", 32'(pend), 32'h00);
    chk("single_valid_clr", 32'(valid), 32'd0);
    chk("single_onehot_clr", 32'(onehot), 32'h00);
    req = 8'h00;
    tick();

    // Fixed priority with ready held high
    req = 8'h81;
    rdy = 1'b1;
    q_fix.push_back(3'd0);
    q_fix.push_back(3'd7);
    tick();
    chk("fp_pend", 32'(pend), 32'h81);
    tick();
    chk("fp_v0", 32'(valid), 32'd1);
    chk("fp_code0", 32'(code), 32'd0);
    tick();
    chk("fp_gap", 32'(valid), 32'd0);
    tick();
    chk("fp_v7", 32'(valid), 32'd1);
    chk("fp_code7", 32'(code), 32'd7);
    tick();
    chk("fp_done", 32'(valid), 32'd0);
    rdy = 1'b0;
    req = 8'h00;
    tick();
    chk("ready_idle_noeffect", 32'(pend), 32'h00);

    // Backpressure and overflow
    req = 8'h08;
    tick();
    tick();
    q_fix.push_back(3'd3);
    req = 8'h00;
    tick();
    req = 8'h08;
    tick();
    chk("bp_ovf_set", 32'(ovf), 32'd1);
    chk("bp_valid", 32'(valid), 32'd1);
    chk("bp_code", 32'(code), 32'd3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("bp_ovf_clr", 32'(ovf), 32'd0);
    chk("bp_code_stable", 32'(code), 32'd3);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("bp_pend_after", 32'(pend), 32'h00);
    req = 8'h00;
    tick();

    // Coincident set and clear on bit 5
    req = 8'h20;
    tick();
    tick();
    q_fix.push_back(3'd5);
    req = 8'h00;
    tick();
    req = 8'h20;
    rdy = 1'b1;
    q_fix.push_back(3'd5);
    tick();
    rdy = 1'b0;
    chk("coin_pend", 32'(pend), 32'h20);
    chk("coin_ovf", 32'(ovf), 32'd0);
    chk("coin_gap", 32'(valid), 32'd0);
    tick();
    chk("coin_regrant_v", 32'(valid), 32'd1);
    chk("coin_regrant_c", 32'(code), 32'd5);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("coin_pend_after", 32'(pend), 32'h00);
    req = 8'h00;
    tick();

    // Asynchronous reset while holding a grant with overflow set
    req = 8'h10;
    tick();
    tick();
    req = 8'h00;
    tick();
    req = 8'h10;
    tick();
    chk("mid_ovf", 32'(ovf), 32'd1);
    chk("mid_valid", 32'(valid), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_onehot", 32'(onehot), 32'h00);
    chk("arst_pend", 32'(pend), 32'h00);
    chk("arst_ovf", 32'(ovf), 32'd0);
    #1 rst = 1'b0;
    tick();
    chk("held_req_pend", 32'(pend), 32'h10);
    tick();
    chk("held_req_code", 32'(code), 32'd4);
    q_fix.push_back(3'd4);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    req = 8'h00;
    tick();

    // Fixed priority ignores last grant
    req = 8'h21;
    rdy = 1'b1;
    q_fix.push_back(3'd0);
    q_fix.push_back(3'd5);
    repeat (5) tick();
    rdy = 1'b0;
    req = 8'h00;
    chk("fp2_pend", 32'(pend), 32'h00);

    // Round-robin: all pending, bit 0 re-requested after its first grant
    req2 = 8'hFF;
    rdy2 = 1'b1;
    for (int i = 0; i < 8; i++) q_rr.push_back(i[2:0]);
    q_rr.push_back(3'd0);
    repeat (3) tick();
    req2 = 8'hFE;
    tick();
    req2 = 8'hFF;
    repeat (20) tick();
    rdy2 = 1'b0;
    chk("rr_pend_after", 32'(pend2), 32'h00);
    chk("rr_ovf", 32'(ovf2), 32'd0);

    repeat (2) tick();
    chk("fix_queue_drained", 32'(q_fix.size()), 32'd0);
    chk("rr_queue_drained", 32'(q_rr.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pending_req_encoder.md
PENDING_REQ_ENCODER -- requirements
Module: pending_req_encoder

Interface
REQ-001 Parameter ROUND_ROBIN, default 0: 0 selects fixed lowest-index priority; 1 selects rotating priority.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_in  input  8  request lines, level inputs, one line per source; a source is indexed 0..7.
REQ-005 out_ready  input  1  downstream accepts the current code when high together with out_valid.
REQ-006 clr_ovf  input  1  synchronous clear of the overflow flag.
REQ-007 out_valid  output  1  out_code and out_onehot hold a granted request.
REQ-008 out_code  output  3  binary index of the granted source.
REQ-009 out_onehot  output  8  one-hot form of out_code; all zeros when out_valid is low.
REQ-010 pend  output  8  current pending-request vector.
REQ-011 overflow  output  1  sticky flag: a request was lost because its source was already pending.

Function
REQ-012 The block SHALL register req_in into req_q every cycle and SHALL form edge = req_in AND NOT req_q.
REQ-013 The block SHALL set pend[i] on any clock edge where edge[i] is 1.
REQ-014 The block SHALL clear pend[i] on the clock edge where out_valid and out_ready are both high and out_code equals i.
REQ-015 If a set and a clear of the same bit coincide, the set SHALL win, the bit SHALL stay 1, and overflow SHALL NOT be set.
REQ-016 The block SHALL set overflow when edge[i] and pend[i] are both 1 and bit i is not being cleared that cycle.
REQ-017 clr_ovf SHALL clear overflow on the next edge; a simultaneous overflow set SHALL win.
REQ-018 The control FSM SHALL have two states: IDLE and HOLD.
REQ-019 IDLE: out_valid is 0 and out_onehot is 0.
REQ-020 IDLE with registered pend nonzero: on the next edge the FSM SHALL latch the selected index into out_code, drive the matching out_onehot, and go to HOLD.
REQ-021 HOLD: out_valid is 1, and out_code and out_onehot SHALL stay stable until accepted, regardless of new requests.
REQ-022 HOLD with out_ready high: on that edge the FSM SHALL return to IDLE, so at least one idle cycle separates grants.
REQ-023 Latency: a request first sampled at edge k sets pend at edge k; out_valid goes high after edge k+1 when the block is idle.
REQ-024 With ROUND_ROBIN=0, the selected index SHALL be the lowest set bit of pend.
REQ-025 With ROUND_ROBIN=1, the search SHALL start at last_grant+1 modulo 8 and wrap from 7 to 0; last_grant updates on each accept.
REQ-026 All 8-bit masks and pointer arithmetic SHALL be modulo 8 with no out-of-range index.
REQ-027 out_ready while in IDLE SHALL have no effect.

Reset
REQ-028 While rst is high, the following SHALL be 0 immediately, without waiting for clk: req_q, pend, out_valid, out_code, out_onehot, overflow, and FSM state (IDLE).
REQ-029 last_grant SHALL reset to 7, so that index 0 has first priority after reset.
REQ-030 A req_in line held high through reset release SHALL count as a new request on the first edge after release.
REQ-031 Reset asserted in HOLD SHALL drop out_valid asynchronously and discard the grant and all pending bits.

Verification
REQ-032 Single request: req_in=8'b0000_0100 from reset idle -> out_valid=1 with out_code=3'd2 and out_onehot=8'b0000_0100 two cycles later; pulse out_ready -> pend=0 and out_valid=0 the next cycle.
REQ-033 Fixed priority: req_in=8'b1000_0001 applied at once, out_ready held high -> grants in order code 0 then 7, each valid one cycle with one idle cycle between.
REQ-034 Round-robin (ROUND_ROBIN=1): pend=8'hFF, out_ready high -> codes 0,1,...,7,0 in that order.
REQ-035 Backpressure and overflow: grant code 3 held with out_ready=0; toggle req_in[3] low then high -> overflow=1 and out_code stays 3; then clr_ovf=1 -> overflow=0.
REQ-036 Coincident set and clear: accept code 5 on the same edge as a new rising edge on req_in[5] -> pend[5] stays 1, overflow stays 0, code 5 is granted again.
REQ-037 Reset mid-HOLD: assert rst between clock edges while out_valid=1 -> out_valid, pend and overflow go to 0 before the next clk edge.
